mul_by2_vec: RTL and testbench

- Inverse of the coprocessor's divide-by-2 vector stage: scales every element of an NINPUTS-element unsigned vector by 2 (left shift by one) with per-element saturation.
- Sits on the result path of the vector datapath, between the arithmetic core and the result serializer.
- Uses a registered valid/ready handshake on both sides, with a 2-entry skid buffer so that backpressure never drops a vector.
- Keeps a per-element saturation mask and a saturating event counter for host readback.

---
 rtl/vec_pkg.sv | 32 +++
 rtl/vec_skid_buf.sv | 81 ++++++++
 rtl/mul_by2_vec.sv | 102 ++++++++++
 tb/tb_mul_by2_vec.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// vec_pkg: shared types and helpers for the vector scaling stages.
//   elem_t      : one vector element (IWIDTH_DEF bits)
//   sat_res_t   : {value, flag} result of a saturating shift
//   sat_shl1()  : left shift by one with saturation; lsb fills bit 0
package vec_pkg;

  localparam int IWIDTH_DEF  = 10;
  localparam int NINPUTS_DEF = 8;
  localparam int CNTW_DEF    = 16;

  typedef logic [IWIDTH_DEF-1:0] elem_t;

  typedef struct packed {
    elem_t value;
    logic  flag;
  } sat_res_t;

  // The shift overflows exactly when the element MSB is set, so that bit
  // alone selects the clamp.
  function automatic sat_res_t sat_shl1(input elem_t elem, input logic lsb);
    sat_res_t res;
    if (elem[IWIDTH_DEF-1]) begin
      res.value = {IWIDTH_DEF{1'b1}};
      res.flag  = 1'b1;
    end else begin
      res.value = {elem[IWIDTH_DEF-2:0], lsb};
      res.flag  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/vec_skid_buf.sv
// vec_skid_buf: 2-entry valid/ready buffer (main output register + skid).
//   clk, rst_n            : clock, async active-low reset
//   in_payload/in_valid   : upstream data and valid
//   in_ready              : registered, high while the skid entry is empty
//   out_payload/out_valid : main entry contents and valid
//   out_ready             : downstream accept
module vec_skid_buf #(
  parameter int W = 88
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_payload,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_payload,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] main_r, main_nx_s;
  logic [W-1:0] skid_r, skid_nx_s;
  logic         main_valid_r, main_valid_nx_s;
  logic         skid_valid_r, skid_valid_nx_s;
  logic         in_ready_r;
  logic         in_xfer_s, out_xfer_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = main_valid_r & out_ready;

  // Next-state for both entries; skid only fills when main is stuck.
  always_comb begin
    main_nx_s       = main_r;
    main_valid_nx_s = main_valid_r;
    skid_nx_s       = skid_r;
    skid_valid_nx_s = skid_valid_r;
    if (skid_valid_r) begin
      // in_ready is low here, so only a drain can happen.
      if (out_xfer_s) begin
        main_nx_s       = skid_r;
        skid_valid_nx_s = 1'b0;
      end else begin
        skid_valid_nx_s = 1'b1;
      end
    end else if (in_xfer_s) begin
      if (!main_valid_r || out_xfer_s) begin
        main_nx_s       = in_payload;
        main_valid_nx_s = 1'b1;
      end else begin
        skid_nx_s       = in_payload;
        skid_valid_nx_s = 1'b1;
      end
    end else if (out_xfer_s) begin
      main_valid_nx_s = 1'b0;
    end else begin
      main_valid_nx_s = main_valid_r;
    end
  end

  // Storage registers; in_ready stays low through reset and rises on the
  // first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r       <= {W{1'b0}};
      skid_r       <= {W{1'b0}};
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      main_r       <= main_nx_s;
      skid_r       <= skid_nx_s;
      main_valid_r <= main_valid_nx_s;
      skid_valid_r <= skid_valid_nx_s;
      in_ready_r   <= ~skid_valid_nx_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = main_valid_r;
  assign out_payload = main_r;

endmodule

// File: rtl/mul_by2_vec.sv
// mul_by2_vec: per-element saturating multiply-by-2 of an unsigned vector,
// with a 2-entry valid/ready buffer and saturation statistics.
//   clk, rst_n           : clock, async active-low reset
//   in_data/in_lsb       : input elements and the bit shifted into bit 0
//   in_valid/in_ready    : input handshake (in_ready registered)
//   out_data/out_sat     : scaled elements and per-element clamp flags
//   out_valid/out_ready  : output handshake
//   sat_clr              : synchronous clear of sat_count / sat_any
//   sat_count/sat_any    : saturating count of clamped vectors, sticky flag
// IWIDTH must match the package element width used by sat_shl1.
module mul_by2_vec
  import vec_pkg::*;
#(
  parameter int IWIDTH  = IWIDTH_DEF,
  parameter int NINPUTS = NINPUTS_DEF,
  parameter int CNTW    = CNTW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IWIDTH-1:0] in_data [NINPUTS],
  input  logic [NINPUTS-1:0] in_lsb,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [IWIDTH-1:0] out_data [NINPUTS],
  output logic [NINPUTS-1:0] out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              sat_clr,
  output logic [CNTW-1:0]   sat_count,
  output logic              sat_any
);

  localparam int EW = IWIDTH + 1;
  localparam int PW = NINPUTS * EW;

  logic [PW-1:0]   in_payload_s;
  logic [PW-1:0]   out_payload_s;
  logic            any_sat_s;
  logic            in_xfer_s;
  sat_res_t        res_s;
  logic [CNTW-1:0] sat_count_r;
  logic            sat_any_r;

  // Scale every element and pack {flag, value} per element for storage.
  always_comb begin
    in_payload_s = {PW{1'b0}};
    any_sat_s    = 1'b0;
    res_s        = '0;
    for (int i = 0; i < NINPUTS; i++) begin
      res_s = sat_shl1(in_data[i], in_lsb[i]);
      in_payload_s[i*EW +: EW] = {res_s.flag, res_s.value};
      any_sat_s = any_sat_s | res_s.flag;
    end
  end

  vec_skid_buf #(.W(PW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_payload  (in_payload_s),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_payload (out_payload_s),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Unpack the main entry back into elements and flags.
  always_comb begin
    out_sat = {NINPUTS{1'b0}};
    for (int i = 0; i < NINPUTS; i++) begin
      out_data[i] = out_payload_s[i*EW +: IWIDTH];
      out_sat[i]  = out_payload_s[i*EW + IWIDTH];
    end
  end

  assign in_xfer_s = in_valid & in_ready;

  // Statistics: clear wins over a same-cycle event; counter clamps at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_r <= {CNTW{1'b0}};
      sat_any_r   <= 1'b0;
    end else if (sat_clr) begin
      sat_count_r <= {CNTW{1'b0}};
      sat_any_r   <= 1'b0;
    end else if (in_xfer_s && any_sat_s) begin
      sat_any_r <= 1'b1;
      if (sat_count_r != {CNTW{1'b1}}) begin
        sat_count_r <= sat_count_r + CNTW'(1);
      end else begin
        sat_count_r <= sat_count_r;
      end
    end else begin
      sat_count_r <= sat_count_r;
      sat_any_r   <= sat_any_r;
    end
  end

  assign sat_count = sat_count_r;
  assign sat_any   = sat_any_r;

endmodule

// File: tb/tb_mul_by2_vec.sv
// Scoreboard bench for mul_by2_vec: the driver pushes the arithmetic
// result of each accepted vector; a monitor pops and compares on each
// output transfer and checks that stalled outputs hold steady.
module tb_mul_by2_vec;

  localparam int IW = 10;
  localparam int N  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] in_data [N];
  logic [N-1:0]  in_lsb;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] out_data [N];
  logic [N-1:0]  out_sat;
  logic          out_valid;
  logic          out_ready;
  logic          sat_clr;
  logic [CW-1:0] sat_count;
  logic          sat_any;

  always #5 clk = ~clk;

  mul_by2_vec #(.IWIDTH(IW), .NINPUTS(N), .CNTW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_lsb    (in_lsb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_clr   (sat_clr),
    .sat_count (sat_count),
    .sat_any   (sat_any)
  );

  typedef struct packed {
    logic [N*IW-1:0] data;
    logic [N-1:0]    sat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  int          n_acc = 0;
  int unsigned m_count = 0;
  bit          m_any = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*IW-1:0] pack_out();
    logic [N*IW-1:0] r;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = out_data[i];
    return r;
  endfunction

  task automatic set_all(input int val);
    for (int i = 0; i < N; i++) in_data[i] = IW'(val);
    in_lsb = '0;
  endtask

  // Reference: value*2 + lsb, clamped to the largest element value.
  task automatic push_expected(output bit any);
    exp_t e;
    int   v;
    any = 1'b0;
    e   = '0;
    for (int i = 0; i < N; i++) begin
      v = int'(in_data[i]) * 2 + int'(in_lsb[i]);
      if (v > (1 << IW) - 1) begin
        e.data[i*IW +: IW] = IW'((1 << IW) - 1);
        e.sat[i] = 1'b1;
        any = 1'b1;
      end else begin
        e.data[i*IW +: IW] = IW'(v);
      end
    end
    sb.push_back(e);
  endtask

  // One clock: sample at negedge, update the model, return to posedge+1.
  task automatic step();
    bit any;
    @(negedge clk);
    chk("sat_count", sat_count, m_count);
    chk("sat_any", sat_any, m_any);
    any = 1'b0;
    if (in_valid && in_ready) begin
      push_expected(any);
      n_acc++;
    end
    if (sat_clr) begin
      m_count = 0;
      m_any   = 1'b0;
    end else if (any) begin
      if (m_count < (1 << CW) - 1) m_count++;
      m_any = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: in-order compare on each output transfer, hold check on stall.
  initial begin
    exp_t            e;
    bit              stalled;
    logic [N*IW-1:0] held_d;
    logic [N-1:0]    held_s;
    stalled = 1'b0;
    held_d  = '0;
    held_s  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_data", pack_out(), held_d);
          chk("hold_sat", out_sat, held_s);
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %0h expected none", pack_out());
          end else begin
            e = sb.pop_front();
            chk("out_data", pack_out(), e.data);
            chk("out_sat", out_sat, e.sat);
          end
        end
        stalled = out_valid && !out_ready;
        held_d  = pack_out();
        held_s  = out_sat;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int cyc;
    bit big;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sat_clr   = 1'b0;
    set_all(0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_data", pack_out(), '0);
    chk("rst_out_sat", out_sat, '0);
    chk("rst_sat_count", sat_count, '0);
    chk("rst_sat_any", sat_any, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", in_ready, 1'b1);

    // Plain doubling, latency 1
    set_all(100);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_elem0", out_data[0], 10'd200);
    chk("t1_elem7", out_data[7], 10'd200);
    chk("t1_sat", out_sat, '0);
    step();

    // One saturating element, one with lsb restored
    set_all(0);
    in_data[3] = 10'd512;
    in_data[0] = 10'd255;
    in_lsb     = 8'h01;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    in_lsb   = '0;
    chk("t2_elem3", out_data[3], 10'd1023);
    chk("t2_sat3", out_sat[3], 1'b1);
    chk("t2_elem0", out_data[0], 10'd511);
    chk("t2_sat0", out_sat[0], 1'b0);
    step();
    chk("t2_count", sat_count, 16'd1);
    chk("t2_any", sat_any, 1'b1);

    // Backpressure fills both entries, then drains in order
    out_ready = 1'b0;
    base = n_out;
    set_all(1);
    in_valid = 1'b1;
    step();
    chk("t3_ready1", in_ready, 1'b1);
    set_all(2);
    step();
    chk("t3_ready2", in_ready, 1'b0);
    set_all(3);
    step();
    chk("t3_ready3", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t3_out_count", n_out - base, 3);
    chk("t3_sb_empty", sb.size(), 0);

    // Clear wins over a simultaneous saturating transfer
    set_all(600);
    in_valid = 1'b1;
    sat_clr  = 1'b1;
    step();
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    chk("clr_count", sat_count, '0);
    chk("clr_any", sat_any, 1'b0);
    step();
    step();

    // Random streaming
    base = n_acc;
    cyc  = 0;
    while ((n_acc - base) < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      big       = $urandom_range(0, 1);
      for (int i = 0; i < N; i++)
        in_data[i] = big ? IW'($urandom_range(0, 1023)) : IW'($urandom_range(0, 511));
      in_lsb = N'($urandom);
      step();
      cyc++;
    end
    chk("rand_accepted", n_acc - base, 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("rand_drain_empty", sb.size(), 0);

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    set_all(5);
    in_valid = 1'b1;
    step();
    set_all(6);
    step();
    in_valid = 1'b0;
    chk("full_valid", out_valid, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_out_data", pack_out(), '0);
    chk("async_in_ready", in_ready, 1'b0);
    sb.delete();
    m_count = 0;
    m_any   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", in_ready, 1'b1);
    base = n_out;
    set_all(7);
    in_lsb    = 8'hFF;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_elem0", out_data[0], 10'd15);
    step();
    chk("post_rst_empty", out_valid, 1'b0);
    chk("post_rst_outs", n_out - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
